// File: rtl/raycast_ctx_stack.sv
// Multi-channel LIFO holding one traversal stack per ray context.
// Top-of-stack, occupancy and error flags of the channel on ch_i are read combinationally.
module raycast_ctx_stack #(
    parameter int dw            = 32,
    parameter int depth         = 8,
    parameter int depth_log2    = 3,
    parameter int channels      = 4,
    parameter int channels_log2 = 2,
    parameter bit wrap_mode     = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [channels_log2-1:0] ch_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [dw-1:0]            data_i,
    output logic [dw-1:0]            data_o,
    output logic [depth_log2:0]      count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     ovf_o,
    output logic                     unf_o
);
    localparam int NCH    = 1 << channels_log2;
    localparam int MEM_AW = channels_log2 + depth_log2;
    localparam logic [depth_log2:0] DEPTH_C = (depth_log2 + 1)'(depth);

    logic [dw-1:0] mem [0:(1 << MEM_AW)-1];

    // Per-channel state views, padded to a power of two so ch_i always indexes in range.
    logic [depth_log2-1:0] ptr_v [NCH];
    logic [depth_log2:0]   cnt_v [NCH];
    logic                  ovf_v [NCH];
    logic                  unf_v [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            if (gi < channels) begin : g_real
                logic [depth_log2-1:0] ptr_q, ptr_d;
                logic [depth_log2:0]   cnt_q, cnt_d;
                logic                  ovf_q, ovf_d;
                logic                  unf_q, unf_d;
                logic                  sel;

                assign sel = (ch_i == channels_log2'(gi));

                always_comb begin
                    ptr_d = ptr_q;
                    cnt_d = cnt_q;
                    ovf_d = ovf_q;
                    unf_d = unf_q;
                    if (sel) begin
                        if (clear) begin
                            ptr_d = '0;
                            cnt_d = '0;
                            ovf_d = 1'b0;
                            unf_d = 1'b0;
                        end else if (push && pop && cnt_q != '0) begin
                            // replace-top: pointer, count and flags all hold
                            ptr_d = ptr_q;
                        end else if (push) begin
                            if (cnt_q != DEPTH_C) begin
                                ptr_d = ptr_q + 1'b1;
                                cnt_d = cnt_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                                if (wrap_mode) begin
                                    ptr_d = ptr_q + 1'b1;
                                end
                            end
                        end else if (pop) begin
                            if (cnt_q != '0) begin
                                ptr_d = ptr_q - 1'b1;
                                cnt_d = cnt_q - 1'b1;
                            end else begin
                                unf_d = 1'b1;
                            end
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        ptr_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                        unf_q <= 1'b0;
                    end else begin
                        ptr_q <= ptr_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        unf_q <= unf_d;
                    end
                end

                assign ptr_v[gi] = ptr_q;
                assign cnt_v[gi] = cnt_q;
                assign ovf_v[gi] = ovf_q;
                assign unf_v[gi] = unf_q;
            end else begin : g_pad
                assign ptr_v[gi] = '0;
                assign cnt_v[gi] = '0;
                assign ovf_v[gi] = 1'b0;
                assign unf_v[gi] = 1'b0;
            end
        end
    endgenerate

    logic [depth_log2-1:0] cur_ptr;
    logic [depth_log2:0]   cur_cnt;
    logic                  replace;
    logic                  wr_en;
    logic [depth_log2-1:0] wr_ptr;

    assign cur_ptr = ptr_v[ch_i];
    assign cur_cnt = cnt_v[ch_i];

    // Single write port: a push lands above the top, a replace overwrites the top.
    always_comb begin
        replace = push && pop && (cur_cnt != '0);
        wr_en   = !rst && !clear && push && (replace || (cur_cnt != DEPTH_C) || wrap_mode);
        wr_ptr  = replace ? cur_ptr : cur_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{ch_i, wr_ptr}] <= data_i;
        end
    end

    always_comb begin
        data_o  = (cur_cnt == '0) ? '0 : mem[{ch_i, cur_ptr}];
        count_o = cur_cnt;
        empty_o = (cur_cnt == '0);
        full_o  = (cur_cnt == DEPTH_C);
        ovf_o   = ovf_v[ch_i];
        unf_o   = unf_v[ch_i];
    end
endmodule

// File: tb/tb_raycast_ctx_stack.sv
// Bench for raycast_ctx_stack: a wrapping and a saturating instance share stimulus,
// each checked against a list-based stack model.
module tb_raycast_ctx_stack;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  ch_i = '0;
    logic        push = 1'b0, pop = 1'b0, clear = 1'b0;
    logic [31:0] data_i = '0;

    logic [31:0] data_w, data_s;
    logic [3:0]  count_w, count_s;
    logic        empty_w, empty_s, full_w, full_s, ovf_w, ovf_s, unf_w, unf_s;

    int tests = 0;
    int fails = 0;

    // Model: per instance (0 = wrap, 1 = saturate) and channel, a list with index 0 oldest.
    logic [31:0] mst  [2][4][8];
    int          mcnt [2][4];
    bit          movf [2][4];
    bit          munf [2][4];

    always #5 clk = ~clk;

    raycast_ctx_stack #(.wrap_mode(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .ch_i(ch_i), .push(push), .pop(pop), .clear(clear),
        .data_i(data_i), .data_o(data_w), .count_o(count_w), .empty_o(empty_w),
        .full_o(full_w), .ovf_o(ovf_w), .unf_o(unf_w)
    );

    raycast_ctx_stack #(.wrap_mode(1'b0)) u_sat (
        .clk(clk), .rst(rst), .ch_i(ch_i), .push(push), .pop(pop), .clear(clear),
        .data_i(data_i), .data_o(data_s), .count_o(count_s), .empty_o(empty_s),
        .full_o(full_s), .ovf_o(ovf_s), .unf_o(unf_s)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s ch%0d: observed %h expected %h", tag, c, got, exp);
        end
    endtask

    task automatic model_apply(input int m, input int c, input bit pu, input bit po,
                               input bit cl, input logic [31:0] d);
        if (cl) begin
            mcnt[m][c] = 0; movf[m][c] = 0; munf[m][c] = 0;
        end else if (pu && po && mcnt[m][c] > 0) begin
            mst[m][c][mcnt[m][c]-1] = d;
        end else if (pu) begin
            if (mcnt[m][c] < 8) begin
                mst[m][c][mcnt[m][c]] = d;
                mcnt[m][c]++;
            end else begin
                movf[m][c] = 1;
                if (m == 0) begin
                    for (int k = 0; k < 7; k++) mst[m][c][k] = mst[m][c][k+1];
                    mst[m][c][7] = d;
                end
            end
        end else if (po) begin
            if (mcnt[m][c] > 0) mcnt[m][c]--;
            else munf[m][c] = 1;
        end
    endtask

    task automatic check_ch(input int c);
        logic [31:0] ed;
        ch_i = 2'(c);
        #1;
        for (int m = 0; m < 2; m++) begin
            ed = (mcnt[m][c] == 0) ? 32'h0 : mst[m][c][mcnt[m][c]-1];
            chk(m == 0 ? "wrap.data"  : "sat.data",  c, m == 0 ? data_w : data_s, ed);
            chk(m == 0 ? "wrap.count" : "sat.count", c, 32'(m == 0 ? count_w : count_s), 32'(mcnt[m][c]));
            chk(m == 0 ? "wrap.empty" : "sat.empty", c, 32'(m == 0 ? empty_w : empty_s), 32'(mcnt[m][c] == 0));
            chk(m == 0 ? "wrap.full"  : "sat.full",  c, 32'(m == 0 ? full_w : full_s), 32'(mcnt[m][c] == 8));
            chk(m == 0 ? "wrap.ovf"   : "sat.ovf",   c, 32'(m == 0 ? ovf_w : ovf_s), 32'(movf[m][c]));
            chk(m == 0 ? "wrap.unf"   : "sat.unf",   c, 32'(m == 0 ? unf_w : unf_s), 32'(munf[m][c]));
        end
    endtask

    task automatic step(input int c, input bit pu, input bit po, input bit cl,
                        input bit r, input logic [31:0] d);
        @(negedge clk);
        ch_i = 2'(c); push = pu; pop = po; clear = cl; rst = r; data_i = d;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                for (int k = 0; k < 4; k++) begin
                    mcnt[m][k] = 0; movf[m][k] = 0; munf[m][k] = 0;
                end
            end else begin
                model_apply(m, c, pu, po, cl, d);
            end
        end
        #1;
        push = 0; pop = 0; clear = 0; rst = 0;
        if (r) begin
            for (int k = 0; k < 4; k++) check_ch(k);
        end else begin
            check_ch(c);
        end
    endtask

    initial begin
        // reset with a push in the same cycle: everything empty afterwards
        step(0, 1, 0, 0, 1, 32'hDEAD);

        // basic push/pop on ch0
        step(0, 1, 0, 0, 0, 32'hA1);
        step(0, 1, 0, 0, 0, 32'hA2);
        step(0, 1, 0, 0, 0, 32'hA3);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);

        // interleaved channels
        step(0, 1, 0, 0, 0, 32'h10);
        step(1, 1, 0, 0, 0, 32'h20);
        step(0, 1, 0, 0, 0, 32'h11);
        check_ch(1);
        check_ch(0);

        // overflow on ch2: wrap instance keeps 9..2, saturating keeps 8..1
        for (int i = 1; i <= 9; i++) step(2, 1, 0, 0, 0, 32'(i));
        for (int i = 0; i < 8; i++) step(2, 0, 1, 0, 0, 0);

        // replace-top, underflow, clear on ch3
        step(3, 1, 0, 0, 0, 32'h55);
        step(3, 1, 1, 0, 0, 32'h66);
        step(3, 0, 1, 0, 0, 0);
        step(3, 0, 1, 0, 0, 0);
        step(3, 0, 0, 1, 0, 0);

        // push+pop on empty ch1 acts as push without underflow
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0, 32'h77);

        // replace while full leaves flags alone
        for (int i = 0; i < 8; i++) step(2, 1, 0, 0, 0, 32'h100 + 32'(i));
        step(2, 1, 1, 0, 0, 32'hBEEF);

        // mid-sequence reset discards same-cycle push
        step(2, 1, 0, 0, 1, 32'h1234);

        // randomized traffic, biased towards filling and draining
        for (int n = 0; n < 600; n++) begin
            int c, op;
            c  = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 99));
            if (op < 45)      step(c, 1, 0, 0, 0, $urandom);
            else if (op < 80) step(c, 0, 1, 0, 0, $urandom);
            else if (op < 93) step(c, 1, 1, 0, 0, $urandom);
            else if (op < 98) step(c, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, 0, $urandom);
            else              step(c, 1, 0, 0, 1, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/raycast_ctx_stack.md
# raycast_ctx_stack

Multi-channel LIFO for ray traversal state. It holds one independent stack per in-flight ray context, selected per cycle by a channel index. Compared with the single-context traversal stack, it adds:
- synchronous reset;
- occupancy, full and empty reporting;
- a selectable overflow policy (wrap or saturate);
- sticky overflow and underflow error flags;
- a same-cycle replace-top operation.

It sits between the raycaster traversal FSM and its per-context register file. Top-of-stack is read combinationally.

## Interface
- dw, 32, data word width
- depth, 8, entries per channel; power of two, ≥2
- depth_log2, 3, log2(depth)
- channels, 4, number of independent stacks; power of two, ≥1
- channels_log2, 2, log2(channels); minimum 1
- wrap_mode, 1, 1 = push on full overwrites oldest entry; 0 = push on full is dropped

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ch_i  in  channels_log2  channel addressed by this cycle's command and by all outputs
- push  in  1  push data_i onto channel ch_i
- pop  in  1  pop top of channel ch_i
- clear  in  1  empty channel ch_i and clear its error flags
- data_i  in  dw  push/replace data
- data_o  out  dw  top entry of ch_i; 0 when ch_i is empty
- count_o  out  depth_log2+1  occupancy of ch_i, 0..depth
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == depth
- ovf_o  out  1  sticky overflow flag of ch_i
- unf_o  out  1  sticky underflow flag of ch_i

## Operation
- Per-channel state:
  - ptr[depth_log2] (index of top);
  - cnt[depth_log2+1];
  - ovf and unf flags;
  - storage mem[channels][depth] (not reset).
- Commands act only on channel ch_i; other channels hold state.
- Priority: rst > clear > (push, pop) combinations.
- rst: every channel ptr=0, cnt=0, ovf=0, unf=0.
- clear: ch_i ptr=0, cnt=0, ovf=0, unf=0; push/pop in the same cycle are ignored.
- push only, cnt<depth: mem[ptr+1]<=data_i, ptr<=ptr+1, cnt<=cnt+1.
- push only, cnt==depth:
  - wrap_mode=1: mem[ptr+1]<=data_i, ptr<=ptr+1, cnt unchanged. The oldest entry is lost and ovf<=1.
  - wrap_mode=0: no write, ptr and cnt unchanged, ovf<=1.
- pop only, cnt>0: ptr<=ptr-1, cnt<=cnt-1. Storage is untouched.
- pop only, cnt==0: ptr and cnt unchanged, unf<=1.
- push and pop, cnt>0: replace top. mem[ptr]<=data_i; ptr and cnt unchanged; no flag change, including when full.
- push and pop, cnt==0: behaves exactly as push only; unf is not set.
- Pointer arithmetic is modulo depth (wraps at depth_log2 bits). cnt saturates at depth and never wraps.
- Flags stay set until clear of that channel or rst.

## Timing
- All outputs are combinational from ch_i and registered state. No latency from ch_i change to outputs.
- A command takes effect at the next rising edge. Its result is visible on outputs in the following cycle, provided ch_i still selects that channel.
- Back-to-back commands on the same channel every cycle are supported. Alternating channels every cycle is supported.
- Outputs after rst, for every channel: data_o=0, count_o=0, empty_o=1, full_o=0, ovf_o=0, unf_o=0.
- rst asserted mid-sequence discards any same-cycle command. Storage contents are not reset, but they are unreachable until pushed again.
- Single write port into storage; at most one storage write per cycle.

## Test plan
- Reset, then push 0xA1, 0xA2, 0xA3 on ch 0 → count_o=3, data_o=0xA3. Three pops → data_o=0xA2, 0xA1, then 0 with empty_o=1.
- Interleave: ch0 push 0x10, ch1 push 0x20, ch0 push 0x11; read ch1 → data_o=0x20, count_o=1. Read ch0 → data_o=0x11, count_o=2.
- wrap_mode=1, depth=8: push 1..9 on ch2 → full_o=1, count_o=8, ovf_o=1. Eight pops return 9..2, then empty_o=1.
- wrap_mode=0, depth=8: push 1..9 → ovf_o=1, data_o=8. Eight pops return 8..1.
- Replace and underflow on ch3: push 0x55, then push+pop with 0x66 → data_o=0x66, count_o=1. Pop twice → empty_o=1, unf_o=1. clear → unf_o=0, count_o=0.
- Push+pop on empty ch1 with 0x77 → count_o=1, data_o=0x77, unf_o=0. rst in the same cycle as a push → count_o=0 on all channels.
